// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate-control command bus: command codes,
// operand widths, command ordering and the controller's power-on view.
package coord_pkg;

  localparam int unsigned OP_W       = 13;
  localparam int unsigned CTRL_W     = 3;
  localparam int unsigned INC_COL_W  = 10;
  localparam int unsigned INC_ROW_W  = 8;
  localparam int unsigned NUM_CMDS   = 6;
  localparam int unsigned IDX_W      = 3;

  localparam logic [CTRL_W-1:0] CTRL_SPIN          = 3'b000;
  localparam logic [CTRL_W-1:0] CTRL_SET_LEFT      = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_SET_TOP       = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_NONE          = 3'b011;
  localparam logic [CTRL_W-1:0] CTRL_SET_INC_COL_X = 3'b100;
  localparam logic [CTRL_W-1:0] CTRL_SET_INC_COL_Y = 3'b101;
  localparam logic [CTRL_W-1:0] CTRL_SET_INC_ROW_X = 3'b110;
  localparam logic [CTRL_W-1:0] CTRL_SET_INC_ROW_Y = 3'b111;

  // Controller defaults expressed as transmitted operands (left=-11<<(BITS-5), top=13<<(BITS-6))
  localparam logic [OP_W-1:0] DEF_OP_LEFT      = 13'h1500;
  localparam logic [OP_W-1:0] DEF_OP_TOP       = 13'h0680;
  localparam logic [OP_W-1:0] DEF_OP_INC_COL_X = 13'h00F0;
  localparam logic [OP_W-1:0] DEF_OP_INC_COL_Y = 13'h0000;
  localparam logic [OP_W-1:0] DEF_OP_INC_ROW_X = 13'h0000;
  localparam logic [OP_W-1:0] DEF_OP_INC_ROW_Y = 13'h1FCD;

  typedef enum logic [IDX_W-1:0] {
    IDX_LEFT      = 3'd0,
    IDX_TOP       = 3'd1,
    IDX_INC_COL_X = 3'd2,
    IDX_INC_COL_Y = 3'd3,
    IDX_INC_ROW_X = 3'd4,
    IDX_INC_ROW_Y = 3'd5
  } cmd_idx_e;

  function automatic logic [CTRL_W-1:0] idx_to_ctrl(input logic [IDX_W-1:0] idx);
    logic [CTRL_W-1:0] c;
    c = CTRL_NONE;
    case (idx)
      IDX_LEFT:      c = CTRL_SET_LEFT;
      IDX_TOP:       c = CTRL_SET_TOP;
      IDX_INC_COL_X: c = CTRL_SET_INC_COL_X;
      IDX_INC_COL_Y: c = CTRL_SET_INC_COL_Y;
      IDX_INC_ROW_X: c = CTRL_SET_INC_ROW_X;
      IDX_INC_ROW_Y: c = CTRL_SET_INC_ROW_Y;
      default:       c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/coord_cmd_writer_if.sv
// Request/command bus between the host register front-end, the command
// writer and the coordinate controller.
interface coord_cmd_if
  import coord_pkg::*;
#(
  parameter int unsigned BITS = 16
);
  logic                 blank;
  logic                 req_valid;
  logic                 req_ready;
  logic [BITS-1:0]      left;
  logic [BITS-1:0]      top;
  logic [INC_COL_W-1:0] inc_col_x;
  logic [INC_COL_W-1:0] inc_col_y;
  logic [INC_ROW_W-1:0] inc_row_x;
  logic [INC_ROW_W-1:0] inc_row_y;
  logic [CTRL_W-1:0]    ctrl;
  logic [OP_W-1:0]      value;
  logic                 busy;
  logic                 done;

  modport master (
    output blank, req_valid, left, top, inc_col_x, inc_col_y, inc_row_x, inc_row_y,
    input  req_ready, ctrl, value, busy, done
  );

  modport slave (
    input  blank, req_valid, left, top, inc_col_x, inc_col_y, inc_row_x, inc_row_y,
    output req_ready, ctrl, value, busy, done
  );
endinterface

// File: rtl/coord_cmd_writer.sv
// Writes a captured view to the coordinate controller as (ctrl, value) commands
// during blanking only. Optional COORD_CMD_SKIP_EN skips operands already written.
module coord_cmd_writer
  import coord_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  coord_cmd_if.slave  cmd_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  localparam logic [NUM_CMDS-1:0] ALL_CMDS = '1;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [OP_W-1:0]     value_q;
  logic                busy_q;
  logic                done_q;
  logic                ready_q;
  logic [OP_W-1:0]     op_q [NUM_CMDS];

  logic [NUM_CMDS-1:0] mismatch;
  logic [NUM_CMDS-1:0] pend;
  logic [NUM_CMDS-1:0] rest;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                sel_last;
  logic                issue_en;

  function automatic logic [OP_W-1:0] fmt_coord(input logic [BITS-1:0] c);
    return c[BITS-1 -: OP_W];
  endfunction

  function automatic logic [OP_W-1:0] fmt_inc_col(input logic [INC_COL_W-1:0] v);
    return {{(OP_W-INC_COL_W){v[INC_COL_W-1]}}, v};
  endfunction

  function automatic logic [OP_W-1:0] fmt_inc_row(input logic [INC_ROW_W-1:0] v);
    return {{(OP_W-INC_ROW_W){v[INC_ROW_W-1]}}, v};
  endfunction

`ifdef COORD_CMD_SKIP_EN
  logic [OP_W-1:0] shadow_q [NUM_CMDS];

  always_comb begin
    mismatch = '0;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      mismatch[i] = (op_q[i] != shadow_q[i]);
    end
  end

  // Shadow mirrors what the controller currently holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q[IDX_LEFT]      <= DEF_OP_LEFT;
      shadow_q[IDX_TOP]       <= DEF_OP_TOP;
      shadow_q[IDX_INC_COL_X] <= DEF_OP_INC_COL_X;
      shadow_q[IDX_INC_COL_Y] <= DEF_OP_INC_COL_Y;
      shadow_q[IDX_INC_ROW_X] <= DEF_OP_INC_ROW_X;
      shadow_q[IDX_INC_ROW_Y] <= DEF_OP_INC_ROW_Y;
    end else if (issue_en) begin
      shadow_q[sel_idx] <= op_q[sel_idx];
    end
  end
`else
  assign mismatch = ALL_CMDS;
`endif

  // Next command to send: lowest pending index at or above idx_q
  always_comb begin
    pend      = mismatch & (ALL_CMDS << idx_q);
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = int'(NUM_CMDS) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
    rest          = pend;
    rest[sel_idx] = 1'b0;
    sel_last      = (rest == '0);
    issue_en      = (state_q != ST_IDLE) && cmd_bus.blank && sel_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ctrl_q  <= CTRL_NONE;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < int'(NUM_CMDS); i++) begin
        op_q[i] <= '0;
      end
    end else begin
      ctrl_q <= CTRL_NONE;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_bus.req_valid && ready_q) begin
            op_q[IDX_LEFT]      <= fmt_coord(cmd_bus.left);
            op_q[IDX_TOP]       <= fmt_coord(cmd_bus.top);
            op_q[IDX_INC_COL_X] <= fmt_inc_col(cmd_bus.inc_col_x);
            op_q[IDX_INC_COL_Y] <= fmt_inc_col(cmd_bus.inc_col_y);
            op_q[IDX_INC_ROW_X] <= fmt_inc_row(cmd_bus.inc_row_x);
            op_q[IDX_INC_ROW_Y] <= fmt_inc_row(cmd_bus.inc_row_y);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT, ST_ISSUE: begin
          if (!cmd_bus.blank) begin
            // Active video: abandon the partial write and restart from LEFT
            idx_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            if (sel_found) begin
              ctrl_q  <= idx_to_ctrl(sel_idx);
              value_q <= op_q[sel_idx];
              idx_q   <= sel_idx + IDX_W'(1);
            end
            if (!sel_found || sel_last) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              idx_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_bus.ctrl      = ctrl_q;
  assign cmd_bus.value     = value_q;
  assign cmd_bus.busy      = busy_q;
  assign cmd_bus.done      = done_q;
  assign cmd_bus.req_ready = ready_q;

endmodule

// File: tb/tb_coord_cmd_writer.sv
// Self-checking bench for coord_cmd_writer: cycle table for the basic write,
// hand sequences for blank drop, busy-ignore, async reset and COORD_CMD_SKIP_EN.
module tb_coord_cmd_writer;

  localparam logic [2:0] NONE = 3'b011;

  typedef struct {
    logic [15:0] left;
    logic [15:0] top;
    logic [9:0]  icx;
    logic [9:0]  icy;
    logic [7:0]  irx;
    logic [7:0]  iry;
  } req_t;

  typedef struct {
    logic        blank;
    logic        rv;
    logic [2:0]  ctrl;
    logic [12:0] value;
    logic        busy;
    logic        done;
    logic        ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  req_t        reqs [4];
  logic [12:0] exp_ops [4][6];
  logic [2:0]  seq_ctrl [6];
  vec_t        vecs [$];

  coord_cmd_if #(.BITS(16)) bus ();

  coord_cmd_writer #(.BITS(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic apply_req(input int r);
    bus.left      = reqs[r].left;
    bus.top       = reqs[r].top;
    bus.inc_col_x = reqs[r].icx;
    bus.inc_col_y = reqs[r].icy;
    bus.inc_row_x = reqs[r].irx;
    bus.inc_row_y = reqs[r].iry;
  endtask

  task automatic step(input logic b, input logic rv);
    @(negedge clk);
    bus.blank     = b;
    bus.req_valid = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] c, input logic [12:0] v,
                       input logic bz, input logic dn, input logic rd);
    n_checks++;
    if ({bus.ctrl, bus.value, bus.busy, bus.done, bus.req_ready} !== {c, v, bz, dn, rd}) begin
      n_fail++;
      $display("FAIL %s: got ctrl=%03b value=%04h busy=%0b done=%0b ready=%0b, want ctrl=%03b value=%04h busy=%0b done=%0b ready=%0b",
               name, bus.ctrl, bus.value, bus.busy, bus.done, bus.req_ready, c, v, bz, dn, rd);
    end
  endtask

  function automatic void add(input logic b, input logic rv, input logic [2:0] c,
                              input logic [12:0] v, input logic bz, input logic dn, input logic rd);
    vec_t t;
    t.blank = b; t.rv = rv; t.ctrl = c; t.value = v; t.busy = bz; t.done = dn; t.ready = rd;
    vecs.push_back(t);
  endfunction

  // Six blank cycles writing request r; done/ready only on the last command
  task automatic issue_all(input int r, input string name);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("%s_cmd%0d", name, k), seq_ctrl[k], exp_ops[r][k],
            (k != 5), (k == 5), (k == 5));
    end
  endtask

  initial begin
    seq_ctrl = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    reqs[0] = '{16'hA800, 16'h3400, 10'd240, 10'd0, 8'h00, 8'hCD};
    reqs[1] = '{16'h1234, 16'hFFF8, 10'h200, 10'h1FF, 8'h80, 8'h7F};
    reqs[2] = '{16'h0008, 16'h0010, 10'h003, 10'h3FF, 8'h01, 8'hFF};
    reqs[3] = '{16'hA800, 16'h3400, 10'd240, 10'd5, 8'h00, 8'hCD};
    exp_ops[0] = '{13'h1500, 13'h0680, 13'h00F0, 13'h0000, 13'h0000, 13'h1FCD};
    exp_ops[1] = '{13'h0246, 13'h1FFF, 13'h1E00, 13'h01FF, 13'h1F80, 13'h007F};
    exp_ops[2] = '{13'h0001, 13'h0002, 13'h0003, 13'h1FFF, 13'h0001, 13'h1FFF};
    exp_ops[3] = '{13'h1500, 13'h0680, 13'h00F0, 13'h0005, 13'h0000, 13'h1FCD};

    rst_n         = 1'b0;
    bus.blank     = 1'b0;
    bus.req_valid = 1'b0;
    apply_req(0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", NONE, 13'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef COORD_CMD_SKIP_EN
    // Idle under blank, capture with blank low, then the full six-command burst
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, NONE, 13'h0000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, NONE, 13'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, NONE, 13'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b001, 13'h1500, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b010, 13'h0680, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b100, 13'h00F0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b101, 13'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b110, 13'h0000, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 13'h1FCD, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, NONE,   13'h1FCD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].blank, vecs[i].rv);
      check($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].value,
            vecs[i].busy, vecs[i].done, vecs[i].ready);
    end

    // Blank drops after three commands: restart from LEFT
    apply_req(1);
    step(1'b0, 1'b1);
    check("accept_b", NONE, 13'h1FCD, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("partial_cmd%0d", k), seq_ctrl[k], exp_ops[1][k], 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    check("blank_drop", NONE, 13'h1E00, 1'b1, 1'b0, 1'b0);
    // New request while busy must not disturb the held one
    apply_req(2);
    step(1'b0, 1'b1);
    check("ignored_busy", NONE, 13'h1E00, 1'b1, 1'b0, 1'b0);
    issue_all(1, "restart");

    step(1'b1, 1'b1);
    check("accept_after_done", NONE, 13'h007F, 1'b1, 1'b0, 1'b0);
    issue_all(2, "second");
    step(1'b1, 1'b0);
    check("idle_after_second", NONE, 13'h1FFF, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst
    apply_req(0);
    step(1'b0, 1'b1);
    check("accept_rst", NONE, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("rst_cmd0", 3'b001, 13'h1500, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("rst_cmd1", 3'b010, 13'h0680, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", NONE, 13'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("post_reset%0d", i), NONE, 13'h0000, 1'b0, 1'b0, 1'b1);
    end
`else
    // Request equal to controller defaults: done on first blank edge, no command
    apply_req(0);
    step(1'b0, 1'b1);
    check("skip_accept", NONE, 13'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("skip_wait%0d", i), NONE, 13'h0000, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0);
    check("skip_all", NONE, 13'h0000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("skip_all_idle", NONE, 13'h0000, 1'b0, 1'b0, 1'b1);

    // Only inc_col_y differs: a single 101 command that also completes
    apply_req(3);
    step(1'b1, 1'b1);
    check("skip_accept_icy", NONE, 13'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("skip_icy", 3'b101, 13'h0005, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("skip_icy_idle", NONE, 13'h0005, 1'b0, 1'b0, 1'b1);

    // Same request again now matches the shadow
    step(1'b1, 1'b1);
    check("skip_again_accept", NONE, 13'h0005, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("skip_again", NONE, 13'h0005, 1'b0, 1'b1, 1'b1);

    // Full request with a blank drop: issued fields are skipped on restart
    apply_req(1);
    step(1'b0, 1'b1);
    check("skip_accept_b", NONE, 13'h0005, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("skip_b0", 3'b001, 13'h0246, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("skip_b1", 3'b010, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("skip_b_drop", NONE, 13'h1FFF, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k < 6; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("skip_b_cmd%0d", k), seq_ctrl[k], exp_ops[1][k],
            (k != 5), (k == 5), (k == 5));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
